// File: rtl/mult_share_arbiter_if.sv
// Bundle of the arbiter's client-side and multiplier-side signals.
// The arbiter connects through the slave modport; the environment that drives
// requests and models the multiplier connects through the master modport.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 14,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] md_in;
    logic [NUM_REQ*WIDTH-1:0] mr_in;
    logic [NUM_REQ-1:0]       ack;
    logic                     err;
    logic [2*WIDTH-1:0]       product_out;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_md;
    logic [WIDTH-1:0]         mul_mr;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_product;

    modport slave (
        input  req, md_in, mr_in, mul_done, mul_product,
        output ack, err, product_out, grant_id, busy, mul_start, mul_md, mul_mr
    );

    modport master (
        output req, md_in, mr_in, mul_done, mul_product,
        input  ack, err, product_out, grant_id, busy, mul_start, mul_md, mul_mr
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among NUM_REQ clients.
// A winner's operands are latched in IDLE, the multiplier is started in LAUNCH,
// WAIT collects the product (or aborts on watchdog), and RESP pulses the ack.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 14,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                  clk,
    input logic                  rst,
    mult_share_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // One extra bit so TIMEOUT-1 always fits, whatever TIMEOUT is.
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [1:0]      state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic [WD_W-1:0] watchdog;

    // First requester at or after last_grant+1, wrapping modulo NUM_REQ.
    // Indices >= NUM_REQ are never produced, so unused codes are never granted.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0]    sel;
        logic               found;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
        return sel;
    endfunction

    // Winner candidate for the current request vector.
    assign pick = rr_pick(bus.req, last_grant);

    // Arbitration FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            last_grant      <= ID_W'(NUM_REQ - 1);
            watchdog        <= '0;
            bus.ack         <= '0;
            bus.err         <= 1'b0;
            bus.product_out <= '0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.mul_start   <= 1'b0;
            bus.mul_md      <= '0;
            bus.mul_mr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        bus.grant_id  <= pick;
                        bus.mul_md    <= WIDTH'(bus.md_in >> (int'(pick) * WIDTH));
                        bus.mul_mr    <= WIDTH'(bus.mr_in >> (int'(pick) * WIDTH));
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // mul_done is deliberately not looked at here.
                    bus.mul_start <= 1'b0;
                    watchdog      <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    // done has priority over a simultaneous timeout.
                    if (bus.mul_done) begin
                        bus.product_out <= bus.mul_product;
                        bus.err         <= 1'b0;
                        bus.ack         <= NUM_REQ'(1) << bus.grant_id;
                        state           <= S_RESP;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        bus.product_out <= '0;
                        bus.err         <= 1'b1;
                        bus.ack         <= NUM_REQ'(1) << bus.grant_id;
                        state           <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Served requester drops to lowest priority for the next round.
                    last_grant      <= bus.grant_id;
                    bus.ack         <= '0;
                    bus.err         <= 1'b0;
                    bus.product_out <= '0;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
